// File: rtl/z80_bus_data_resolver_pkg.sv
// Shared types for the Z80 CPU-side data-bus resolver: cycle decode, wait-FSM
// states and the default value returned on an idle or released bus.
package z80_bus_data_resolver_pkg;

  localparam logic [7:0] IDLE_VAL_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    CYC_IDLE  = 2'd0,
    CYC_READ  = 2'd1,
    CYC_WRITE = 2'd2,
    CYC_INTA  = 2'd3
  } cyc_t;

  typedef enum logic [1:0] {
    WS_IDLE = 2'd0,
    WS_WAIT = 2'd1,
    WS_HOLD = 2'd2
  } wstate_t;

  // Interrupt acknowledge outranks any strobe that happens to be low with it.
  function automatic cyc_t decode_cycle(input logic m1_n, input logic mreq_n,
                                        input logic iorq_n, input logic rd_n,
                                        input logic wr_n);
    if (!m1_n && !iorq_n)               return CYC_INTA;
    if ((!mreq_n || !iorq_n) && !rd_n)  return CYC_READ;
    if ((!mreq_n || !iorq_n) && !wr_n)  return CYC_WRITE;
    return CYC_IDLE;
  endfunction

endpackage

// File: rtl/z80_prio_select.sv
// Fixed-priority request encoder: lowest asserted index wins; also flags
// whether any request is present and whether two or more collide.
module z80_prio_select #(
  parameter int NCHAN = 4,
  parameter int IDXW  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic [NCHAN-1:0] req_i,
  output logic [IDXW-1:0]  idx_o,
  output logic             valid_o,
  output logic             multi_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path through
    // the block leaves it unassigned, which would infer a latch.
    idx_o = '0;
    // Walk downwards so the lowest asserted index is the last one written.
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDXW'(i);
    end
  end

  assign valid_o = |req_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = (req_i & (req_i - NCHAN'(1))) != '0;

endmodule

// File: rtl/z80_bus_data_resolver.sv
// CPU data-input resolver: priority merge of NCHAN read sources, IM2 vector,
// floating-bus emulation, collision flag and per-channel wait-state insertion.
module z80_bus_data_resolver
  import z80_bus_data_resolver_pkg::*;
#(
  parameter int         NCHAN     = 4,
  parameter int         WAITW     = 3,
  parameter bit         FLOAT_BUS = 1'b1,
  parameter logic [7:0] IDLE_VAL  = IDLE_VAL_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clk_enable,
  input  logic                   m1_n,
  input  logic                   mreq_n,
  input  logic                   iorq_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  input  logic                   busak_n,
  input  logic [7:0]             cpu_dout,
  input  logic [8*NCHAN-1:0]     src_data,
  input  logic [NCHAN-1:0]       src_oe,
  input  logic [WAITW*NCHAN-1:0] src_wait,
  input  logic [7:0]             int_vector,
  input  logic                   coll_clr,
  output logic [7:0]             cpu_di,
  output logic                   wait_n,
  output logic [7:0]             last_val,
  output logic                   collision
);

  localparam int IDXW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic             rd_cyc, wr_cyc, inta, act, strobe_off;
  cyc_t             cyc;
  logic [IDXW-1:0]  sel_idx, wait_idx;
  logic             sel_valid, sel_multi;
  logic [7:0]       ch_data;
  logic [WAITW-1:0] start_wait;

  logic [7:0]       cpu_di_q, cpu_di_d;
  logic [7:0]       last_val_q, last_val_d;
  logic             coll_q, coll_d;

  wstate_t          state_q, state_d;
  logic [WAITW-1:0] cnt_q, cnt_d;
  logic             prev_act_q, prev_act_d;
  logic             start_tick;

  assign rd_cyc     = (!mreq_n || !iorq_n) && !rd_n;
  assign wr_cyc     = (!mreq_n || !iorq_n) && !wr_n;
  assign inta       = !m1_n && !iorq_n;
  assign act        = rd_cyc || wr_cyc;
  assign strobe_off = rd_n && wr_n;
  assign cyc        = decode_cycle(m1_n, mreq_n, iorq_n, rd_n, wr_n);

  z80_prio_select #(
    .NCHAN (NCHAN),
    .IDXW  (IDXW)
  ) u_prio (
    .req_i   (src_oe),
    .idx_o   (sel_idx),
    .valid_o (sel_valid),
    .multi_o (sel_multi)
  );

  // Writes and unclaimed reads take their wait count from channel 0.
  assign wait_idx = (rd_cyc && sel_valid) ? sel_idx : '0;

  always_comb begin
    ch_data    = '0;
    start_wait = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (sel_idx == IDXW'(i))  ch_data    = src_data[8*i +: 8];
      if (wait_idx == IDXW'(i)) start_wait = src_wait[WAITW*i +: WAITW];
    end
  end

  always_comb begin
    cpu_di_d = IDLE_VAL;
    if (cyc == CYC_INTA)       cpu_di_d = int_vector;
    else if (!busak_n)         cpu_di_d = IDLE_VAL;
    else if (cyc == CYC_READ)  cpu_di_d = sel_valid ? ch_data
                                        : (FLOAT_BUS ? last_val_q : IDLE_VAL);
  end

  always_comb begin
    last_val_d = last_val_q;
    if (!inta && busak_n) begin
      if (wr_cyc)                     last_val_d = cpu_dout;
      else if (rd_cyc && sel_valid)   last_val_d = ch_data;
    end
  end

  // A set in the same cycle as a clear wins.
  assign coll_d = (rd_cyc && sel_multi) || (coll_q && !coll_clr);

  // NOTE: reset is asynchronous (listed in the sensitivity list) and every
  // register here is given an explicit reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_di_q   <= IDLE_VAL;
      last_val_q <= IDLE_VAL;
      coll_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      cpu_di_q   <= cpu_di_d;
      last_val_q <= last_val_d;
      coll_q     <= coll_d;
    end
  end

  // Wait FSM: state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WS_IDLE;
      cnt_q      <= '0;
      prev_act_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_act_q <= prev_act_d;
    end
  end

  // A start is a tick seeing a strobe that the previous tick did not see.
  assign start_tick = clk_enable && act && !prev_act_q && !inta && busak_n;

  // Wait FSM: next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_act_d = clk_enable ? act : prev_act_q;
    unique case (state_q)
      WS_IDLE, WS_HOLD: begin
        if (start_tick) begin
          cnt_d   = start_wait;
          state_d = (start_wait != '0) ? WS_WAIT : WS_HOLD;
        end else if (state_q == WS_HOLD && strobe_off) begin
          state_d = WS_IDLE;
        end
      end
      WS_WAIT: begin
        if (strobe_off) begin
          state_d = WS_IDLE;
          cnt_d   = '0;
        end else if (clk_enable) begin
          if (cnt_q <= WAITW'(1)) state_d = WS_HOLD;
          if (cnt_q != '0)        cnt_d   = cnt_q - WAITW'(1);
        end
      end
      default: state_d = WS_IDLE;
    endcase
  end

  // Wait FSM: outputs. Gated by the strobe so an aborted cycle releases at once.
  always_comb begin
    wait_n = !(state_q == WS_WAIT && !strobe_off);
  end

  assign cpu_di    = cpu_di_q;
  assign last_val  = last_val_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_z80_bus_data_resolver.sv
// Directed bench for z80_bus_data_resolver: a vector table for the data path
// plus hand-written wait-state, abort and reset sequences.
module tb_z80_bus_data_resolver;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        reset_n, clk_enable;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, busak_n;
  logic [7:0]  cpu_dout, int_vector;
  logic [31:0] src_data;
  logic [3:0]  src_oe;
  logic [11:0] src_wait;
  logic        coll_clr;

  logic [7:0]  cpu_di, last_val, cpu_di_nf, last_val_nf;
  logic        wait_n, collision, wait_n_nf, collision_nf;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  z80_bus_data_resolver #(.NCHAN(4), .WAITW(3), .FLOAT_BUS(1'b1), .IDLE_VAL(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .m1_n(m1_n), .mreq_n(mreq_n),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .busak_n(busak_n), .cpu_dout(cpu_dout),
    .src_data(src_data), .src_oe(src_oe), .src_wait(src_wait), .int_vector(int_vector),
    .coll_clr(coll_clr), .cpu_di(cpu_di), .wait_n(wait_n), .last_val(last_val),
    .collision(collision)
  );

  z80_bus_data_resolver #(.NCHAN(4), .WAITW(3), .FLOAT_BUS(1'b0), .IDLE_VAL(8'hFF)) dut_nf (
    .clk(clk), .reset_n(reset_n), .clk_enable(clk_enable), .m1_n(m1_n), .mreq_n(mreq_n),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .busak_n(busak_n), .cpu_dout(cpu_dout),
    .src_data(src_data), .src_oe(src_oe), .src_wait(src_wait), .int_vector(int_vector),
    .coll_clr(coll_clr), .cpu_di(cpu_di_nf), .wait_n(wait_n_nf), .last_val(last_val_nf),
    .collision(collision_nf)
  );

  typedef struct {
    string      name;
    logic       mreq_n, iorq_n, m1_n, rd_n, wr_n, busak_n, clr;
    logic [3:0] oe;
    logic [7:0] dout;
    logic [7:0] exp_di, exp_di_nf, exp_last;
    logic       exp_coll;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", name, actual, expected);
    end
  endtask

  task automatic set_bus(input logic mq, input logic io, input logic m1,
                         input logic rd, input logic wr, input logic bk);
    mreq_n = mq; iorq_n = io; m1_n = m1; rd_n = rd; wr_n = wr; busak_n = bk;
  endtask

  task automatic tick();
    clk_enable = 1'b1;
    @(posedge clk); #1;
    clk_enable = 1'b0;
    @(posedge clk); #1;
  endtask

  // Counts the CPU samples (clk_enable ticks) at which wait_n is seen low.
  task automatic count_low(input int ticks, output int n);
    n = 0;
    for (int i = 0; i < ticks; i++) begin
      if (wait_n === 1'b0) n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;

    //             name          mreq iorq m1 rd wr bk clr  oe       dout   di     di_nf  last   coll
    vecs[0]  = '{"idle",         H,   H,   H, H, H, H, L, 4'b0000, 8'h00, 8'hFF, 8'hFF, 8'hFF, L};
    vecs[1]  = '{"rd_multi",     L,   H,   H, L, H, H, L, 4'b0110, 8'h00, 8'h3C, 8'h3C, 8'h3C, H};
    vecs[2]  = '{"coll_clr",     H,   H,   H, H, H, H, H, 4'b0000, 8'h00, 8'hFF, 8'hFF, 8'h3C, L};
    vecs[3]  = '{"wr_a5",        L,   H,   H, H, L, H, L, 4'b0000, 8'hA5, 8'hFF, 8'hFF, 8'hA5, L};
    vecs[4]  = '{"rd_float",     L,   H,   H, L, H, H, L, 4'b0000, 8'h00, 8'hA5, 8'hFF, 8'hA5, L};
    vecs[5]  = '{"io_rd_ch3",    H,   L,   H, L, H, H, L, 4'b1000, 8'h00, 8'h99, 8'h99, 8'h99, L};
    vecs[6]  = '{"set_wins",     L,   H,   H, L, H, H, H, 4'b1111, 8'h00, 8'h11, 8'h11, 8'h11, H};
    vecs[7]  = '{"coll_sticky",  H,   H,   H, H, H, H, L, 4'b0000, 8'h00, 8'hFF, 8'hFF, 8'h11, H};
    vecs[8]  = '{"coll_clr2",    H,   H,   H, H, H, H, H, 4'b0000, 8'h00, 8'hFF, 8'hFF, 8'h11, L};
    vecs[9]  = '{"inta",         H,   L,   L, H, H, H, L, 4'b0001, 8'h00, 8'hFE, 8'hFE, 8'h11, L};
    vecs[10] = '{"busak_rd",     L,   H,   H, L, H, L, L, 4'b0010, 8'h00, 8'hFF, 8'hFF, 8'h11, L};
    vecs[11] = '{"wr_5a",        L,   H,   H, H, L, H, L, 4'b0100, 8'h5A, 8'hFF, 8'hFF, 8'h5A, L};
    vecs[12] = '{"rd_float2",    L,   H,   H, L, H, H, L, 4'b0000, 8'h00, 8'h5A, 8'hFF, 8'h5A, L};
    vecs[13] = '{"idle_end",     H,   H,   H, H, H, H, L, 4'b0000, 8'h00, 8'hFF, 8'hFF, 8'h5A, L};

    reset_n    = 1'b0;
    clk_enable = 1'b0;
    set_bus(H, H, H, H, H, H);
    cpu_dout   = 8'h00;
    int_vector = 8'hFE;
    src_data   = {8'h99, 8'h55, 8'h3C, 8'h11};
    src_oe     = 4'b0000;
    src_wait   = '0;
    coll_clr   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset.cpu_di",    cpu_di,             8'hFF);
    check("reset.last_val",  last_val,           8'hFF);
    check("reset.wait_n",    {7'b0, wait_n},     8'h01);
    check("reset.collision", {7'b0, collision},  8'h00);
    reset_n = 1'b1;

    // Data path, clk_enable held low so the wait FSM stays out of the way.
    foreach (vecs[k]) begin
      set_bus(vecs[k].mreq_n, vecs[k].iorq_n, vecs[k].m1_n, vecs[k].rd_n,
              vecs[k].wr_n, vecs[k].busak_n);
      coll_clr = vecs[k].clr;
      src_oe   = vecs[k].oe;
      cpu_dout = vecs[k].dout;
      @(posedge clk); #1;
      check($sformatf("%s.cpu_di", vecs[k].name),      cpu_di,                 vecs[k].exp_di);
      check($sformatf("%s.cpu_di_nf", vecs[k].name),   cpu_di_nf,              vecs[k].exp_di_nf);
      check($sformatf("%s.last_val", vecs[k].name),    last_val,               vecs[k].exp_last);
      check($sformatf("%s.last_val_nf", vecs[k].name), last_val_nf,            vecs[k].exp_last);
      check($sformatf("%s.collision", vecs[k].name),   {7'b0, collision},      {7'b0, vecs[k].exp_coll});
      check($sformatf("%s.wait_n", vecs[k].name),      {7'b0, wait_n},         8'h01);
    end
    coll_clr = 1'b0;

    // Read claimed by ch2 with 3 wait states.
    src_wait = {3'd0, 3'd3, 3'd0, 3'd0};
    src_oe   = 4'b0100;
    tick();
    set_bus(L, H, H, L, H, H);
    count_low(8, n);
    check("wait3.ticks_low", 8'(n), 8'd3);
    check("wait3.cpu_di", cpu_di, 8'h55);
    check("wait3.hold_wait_n", {7'b0, wait_n}, 8'h01);
    set_bus(H, H, H, H, H, H);
    tick();

    // Zero wait states: no low pulse at all.
    src_wait = '0;
    set_bus(L, H, H, L, H, H);
    count_low(6, n);
    check("wait0.ticks_low", 8'(n), 8'd0);
    set_bus(H, H, H, H, H, H);
    tick();

    // Write takes channel 0's count even though ch1 claims the bus.
    src_wait = {3'd0, 3'd0, 3'd7, 3'd2};
    src_oe   = 4'b0010;
    set_bus(L, H, H, H, L, H);
    count_low(6, n);
    check("wr_ch0_wait2.ticks_low", 8'(n), 8'd2);
    set_bus(H, H, H, H, H, H);
    tick();

    // Maximum count on a read claimed by ch1.
    set_bus(L, H, H, L, H, H);
    count_low(12, n);
    check("wait_max7.ticks_low", 8'(n), 8'd7);
    set_bus(H, H, H, H, H, H);
    tick();

    // Bus granted away: no wait states inserted.
    src_wait = {3'd0, 3'd3, 3'd0, 3'd0};
    src_oe   = 4'b0100;
    set_bus(L, H, H, L, H, L);
    count_low(6, n);
    check("busak.ticks_low", 8'(n), 8'd0);
    set_bus(H, H, H, H, H, H);
    tick();

    // Strobe removed while waiting: release immediately, then restart cleanly.
    set_bus(L, H, H, L, H, H);
    tick();
    check("abort.wait_entered", {7'b0, wait_n}, 8'h00);
    set_bus(H, H, H, H, H, H);
    #1;
    check("abort.wait_n_now", {7'b0, wait_n}, 8'h01);
    tick();
    check("abort.wait_n_idle", {7'b0, wait_n}, 8'h01);
    set_bus(L, H, H, L, H, H);
    tick();
    check("abort.restart", {7'b0, wait_n}, 8'h00);
    set_bus(H, H, H, H, H, H);
    tick();

    // Reset in the middle of a wait; strobe still active after release.
    set_bus(L, H, H, L, H, H);
    tick();
    check("rst.wait_entered", {7'b0, wait_n}, 8'h00);
    #2 reset_n = 1'b0;
    #1;
    check("rst.wait_n",    {7'b0, wait_n},    8'h01);
    check("rst.cpu_di",    cpu_di,            8'hFF);
    check("rst.last_val",  last_val,          8'hFF);
    check("rst.collision", {7'b0, collision}, 8'h00);
    reset_n = 1'b1;
    #1;
    check("rst.idle_after", {7'b0, wait_n}, 8'h01);
    tick();
    check("rst.new_start", {7'b0, wait_n}, 8'h00);
    count_low(6, n);
    check("rst.ticks_low", 8'(n), 8'd3);
    set_bus(H, H, H, H, H, H);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/z80_bus_data_resolver.md
# z80_bus_data_resolver

Parametrised CPU-side data-bus resolver for the Z80 soft core: merges NCHAN peripheral read sources onto the CPU data input with fixed priority. It emulates floating-bus or idle-0xFF reads, supplies the IM2 vector on interrupt acknowledge, and inserts per-channel programmable wait states. It sits between the T80 CPU instance and the memory/ULA/peripheral read multiplexers.

## Interface
- NCHAN, 4, number of read sources (1..8); channel 0 has highest priority
- WAITW, 3, width of per-channel wait-state count
- FLOAT_BUS, 1, 1 = unclaimed reads return last bus value; 0 = return IDLE_VAL
- IDLE_VAL, 8'hFF, value for unclaimed reads when FLOAT_BUS=0 and while bus is granted away
- clk  in  1  system clock, single clock domain; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- clk_enable  in  1  CPU clock enable, same strobe fed to the CPU
- m1_n, mreq_n, iorq_n, rd_n, wr_n, busak_n  in  1 each  CPU bus control
- cpu_dout  in  8  CPU write data
- src_data  in  8*NCHAN  read data, channel i at bits [8i+7:8i]
- src_oe  in  NCHAN  channel i claims the current read
- src_wait  in  WAITW*NCHAN  wait states requested by channel i
- int_vector  in  8  byte returned during interrupt acknowledge
- coll_clr  in  1  clears collision flag
- cpu_di  out  8  data to CPU
- wait_n  out  1  to CPU WAIT_n
- last_val  out  8  last value seen on bus
- collision  out  1  sticky: two or more src_oe asserted in a read

## Operation
- Cycle decode, combinational from inputs: rd_cyc = (!mreq_n || !iorq_n) && !rd_n; wr_cyc = (!mreq_n || !iorq_n) && !wr_n; inta = !m1_n && !iorq_n.
- Read source selection, priority order:
  - inta → int_vector;
  - busak_n=0 → IDLE_VAL;
  - rd_cyc with any src_oe → lowest-index asserted channel;
  - rd_cyc, none → last_val if FLOAT_BUS else IDLE_VAL;
  - otherwise IDLE_VAL.
- cpu_di is registered: it updates every clk with the selected value (not gated by clk_enable).
- last_val update:
  - on wr_cyc it loads cpu_dout;
  - on rd_cyc with a claiming channel it loads that channel's data;
  - it holds otherwise, and does not update during inta or busak_n=0.
- Collision: during rd_cyc, popcount(src_oe) ≥ 2 sets collision. coll_clr clears it; if set and clear occur in the same cycle, set wins.
- Wait FSM states and transitions:
  - IDLE: on a clk_enable tick where (rd_cyc || wr_cyc) starts (previous tick neither), load cnt with src_wait of the selected channel. For writes, and for reads with no claiming channel, use channel 0's src_wait. If cnt≠0 go to WAIT, else go to HOLD.
  - WAIT: cnt decrements on each clk_enable; at cnt=1 plus tick, go to HOLD.
  - HOLD: remain until the strobe deasserts (rd_n && wr_n), then go to IDLE.
- wait_n = 0 only in WAIT. No wait states during inta or busak_n=0.
- Strobe removal while in WAIT (abnormal): return to IDLE immediately, wait_n=1.

## Timing
- Reset values: cpu_di=IDLE_VAL, last_val=IDLE_VAL, wait_n=1, collision=0, FSM=IDLE, cnt=0.
- cpu_di latency: 1 clk from input change.
- Cycle-start detection and wait_n assertion: registered at the same clk as the clk_enable tick that sees the strobe, so wait_n is low before the CPU's next clk_enable sample.
- Wait length: exactly N clk_enable ticks with wait_n low for src_wait=N. N=0 → no low pulse. Maximum is 2^WAITW−1.
- cnt is WAITW bits; it never wraps and stops at 0.
- A new cycle starting in the same tick the previous one ends is treated as a new start.
- reset_n asserted mid-cycle forces all reset values asynchronously. After release, the FSM waits in IDLE for the next strobe edge; a strobe already active counts as a new start on the first tick.

## Structure
- Shared package: cycle-type encoding (IDLE/READ/WRITE/INTA), FSM state encoding, and the IDLE_VAL default constant.
- One sub-module: z80_prio_select (NCHAN-way priority encoder returning index, valid and multiple-hit flag).
- The remaining logic (FSM, registers) lives in the top level.

## Test plan
- Reset, then no activity → cpu_di=8'hFF, wait_n=1, last_val=8'hFF, collision=0.
- Read, src_oe=4'b0110, ch1=8'h3C, ch2=8'h55 → cpu_di=8'h3C one clk later; collision=1; last_val=8'h3C. Then coll_clr → collision=0.
- Write 8'hA5, then read with src_oe=0:
  - FLOAT_BUS=1 → cpu_di=8'hA5;
  - rerun with FLOAT_BUS=0 → 8'hFF.
- Read claiming ch2 with src_wait[ch2]=3 → wait_n low for exactly 3 clk_enable ticks, then 1 until the next cycle. With src_wait=0 → wait_n never low.
- Interrupt acknowledge (m1_n=0, iorq_n=0), int_vector=8'hFE, src_oe=4'b0001 → cpu_di=8'hFE, wait_n=1, last_val unchanged.
- busak_n=0 with src_oe asserted → cpu_di=8'hFF. Separately, reset_n asserted during WAIT → wait_n=1 immediately and FSM in IDLE.
